// File: rtl/key_pkg.sv
// Shared definitions for key input handling: FSM state type and board timing constants.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        DOWN       = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    // System clock frequency; one second of hold time in cycles.
    localparam int unsigned CLK_HZ  = 25000000;

    // 20 ms debounce window at CLK_HZ.
    localparam int unsigned DB_20MS = 500000;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit double-flop synchroniser for asynchronous inputs.
// RST_VAL sets the value both flops take during reset, so the output
// starts at the input's idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_detector.sv
// Push-button front end: synchronises one raw key pin, debounces it and
// produces a clean pressed level plus one-cycle press, release and
// long-press pulses.
module key_debounce_detector
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = DB_20MS,
    parameter int unsigned LONG_CYC       = CLK_HZ,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
    localparam int unsigned HW = $clog2(LONG_CYC);

    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HCNT_MAX = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HCNT_PRE = HW'(LONG_CYC - 2);

    logic          key_s;
    logic          pressed_s;
    key_state_t    state;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;

    // Synchroniser idles at the released pin value, so a key held through
    // reset is seen as a fresh press after the full debounce.
    sync_2ff #(
        .RST_VAL (KEY_ACTIVE_LOW)
    ) u_key_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_in),
        .q     (key_s)
    );

    // Normalise polarity so 1 always means pressed.
    assign pressed_s = key_s ^ KEY_ACTIVE_LOW;

    // Debounce / hold FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dcnt        <= '0;
            hcnt        <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed_s) begin
                        state <= PRESS_DB;
                        dcnt  <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!pressed_s) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (dcnt == DCNT_MAX) begin
                        state     <= DOWN;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                        hcnt      <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                DOWN: begin
                    // hcnt only advances while still held, so the long pulse
                    // can never land in the first release-debounce cycle.
                    if (!pressed_s) begin
                        state <= RELEASE_DB;
                        dcnt  <= '0;
                    end else if (hcnt != HCNT_MAX) begin
                        hcnt <= hcnt + 1'b1;
                        if (hcnt == HCNT_PRE) begin
                            key_long <= 1'b1;
                        end
                    end
                end
                RELEASE_DB: begin
                    // hcnt is left untouched so release bounce keeps long timing.
                    if (pressed_s) begin
                        state <= DOWN;
                    end else if (dcnt == DCNT_MAX) begin
                        state       <= IDLE;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
